// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the IF/ID/EX/DM/WB datapath.
// Walks each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every
// datapath enable, handles memory wait states with a timeout, interrupt
// entry at retire and an optional retire-count halt.
module mc_sequencer #(
    parameter int WAIT_MAX  = 8,
    parameter int MAX_INSTR = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             int_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             reg_dst,
    output logic             alu_src,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem2reg,
    output logic [1:0]       alu_op,
    output logic             int_ack,
    output logic             illegal,
    output logic             bus_err,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_ENTRY, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE, K_LW, K_SW, K_BEQ, K_J, K_ILL
    } class_t;

    // Last wait cycle index: the WAIT_MAX-th non-ready cycle still accepts ready.
    localparam logic [7:0]       WAIT_LAST = 8'(WAIT_MAX - 1);
    localparam logic [CNT_W-1:0] HALT_AT   = CNT_W'(MAX_INSTR);
    localparam bit               HALT_EN   = (MAX_INSTR != 0);

    function automatic class_t decode_op(input logic [5:0] op);
        case (op)
            6'h00:   decode_op = K_RTYPE;
            6'h23:   decode_op = K_LW;
            6'h2B:   decode_op = K_SW;
            6'h04:   decode_op = K_BEQ;
            6'h02:   decode_op = K_J;
            default: decode_op = K_ILL;
        endcase
    endfunction

    state_t           r_state;
    state_t           w_next;
    class_t           r_class;
    class_t           w_dec;
    logic [7:0]       r_wait;
    logic [CNT_W-1:0] r_retired;
    logic [CNT_W-1:0] w_ret_inc;
    logic             r_illegal;
    logic             r_bus_err;
    logic             w_retire;
    logic             w_timeout;
    logic             w_set_ill;
    logic             w_waiting;
    logic             w_imem_req, w_dmem_req, w_ir_we, w_pc_we;
    logic [1:0]       w_pc_sel, w_alu_op;
    logic             w_reg_dst, w_alu_src, w_reg_write;
    logic             w_mem_read, w_mem_write, w_mem2reg, w_int_ack;

    // Opcode class, saturating retire increment and memory-wait detection.
    always_comb begin
        w_dec     = decode_op(opcode);
        w_ret_inc = (r_retired == {CNT_W{1'b1}}) ? r_retired : r_retired + CNT_W'(1);
        w_waiting = ((r_state == S_FETCH) && !imem_ready) ||
                    ((r_state == S_MEM)   && !dmem_ready);
    end

    // Next-state and datapath enables from state, registered class and handshakes.
    always_comb begin
        w_next      = r_state;
        w_imem_req  = 1'b0;
        w_dmem_req  = 1'b0;
        w_ir_we     = 1'b0;
        w_pc_we     = 1'b0;
        w_pc_sel    = 2'b00;
        w_reg_dst   = 1'b0;
        w_alu_src   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_mem2reg   = 1'b0;
        w_alu_op    = 2'b00;
        w_int_ack   = 1'b0;
        w_retire    = 1'b0;
        w_timeout   = 1'b0;
        w_set_ill   = 1'b0;
        case (r_state)
            S_ENTRY: begin
                w_pc_we  = 1'b1;
                w_pc_sel = 2'b11;
                w_next   = S_FETCH;
            end
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ready) begin
                    w_ir_we = 1'b1;
                    w_pc_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (r_wait == WAIT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_DECODE: begin
                if (w_dec == K_ILL) begin
                    w_set_ill = 1'b1;
                    w_next    = S_FETCH;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (r_class)
                    K_RTYPE: begin
                        w_reg_dst = 1'b1;
                        w_alu_op  = 2'b10;
                        w_next    = S_WB;
                    end
                    K_LW, K_SW: begin
                        w_alu_src = 1'b1;
                        w_next    = S_MEM;
                    end
                    K_BEQ: begin
                        w_alu_op = 2'b01;
                        w_pc_sel = 2'b01;
                        w_pc_we  = zero;
                        w_retire = 1'b1;
                    end
                    K_J: begin
                        w_pc_sel = 2'b10;
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                    end
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEM: begin
                w_dmem_req  = 1'b1;
                w_alu_src   = 1'b1;
                w_mem_read  = (r_class == K_LW);
                w_mem_write = (r_class == K_SW);
                if (dmem_ready) begin
                    if (r_class == K_SW) begin
                        w_retire = 1'b1;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (r_wait == WAIT_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end else begin
                    w_next = S_MEM;
                end
            end
            S_WB: begin
                w_reg_write = 1'b1;
                w_mem2reg   = (r_class == K_LW);
                w_reg_dst   = (r_class == K_RTYPE);
                // The ALU result still feeds the write port for rtype.
                w_alu_op    = (r_class == K_RTYPE) ? 2'b10 : 2'b00;
                w_retire    = 1'b1;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_ENTRY;
        endcase

        // Retire resolution: halt count beats interrupt, interrupt beats fetch.
        if (w_retire) begin
            if (HALT_EN && (w_ret_inc == HALT_AT)) begin
                w_next = S_HALT;
            end else if (int_req) begin
                w_int_ack = 1'b1;
                w_next    = S_ENTRY;
            end else begin
                w_next = S_FETCH;
            end
        end else begin
            w_int_ack = 1'b0;
        end
    end

    // State, instruction class, wait counter, retire count and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_ENTRY;
            r_class   <= K_RTYPE;
            r_wait    <= 8'd0;
            r_retired <= {CNT_W{1'b0}};
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_dec;
            end
            r_wait <= w_waiting ? r_wait + 8'd1 : 8'd0;
            if (w_retire) begin
                r_retired <= w_ret_inc;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Enables are forced low while rst_n is low so no write escapes a reset.
    assign imem_req  = w_imem_req  & rst_n;
    assign dmem_req  = w_dmem_req  & rst_n;
    assign ir_we     = w_ir_we     & rst_n;
    assign pc_we     = w_pc_we     & rst_n;
    assign pc_sel    = w_pc_sel    & {2{rst_n}};
    assign reg_dst   = w_reg_dst   & rst_n;
    assign alu_src   = w_alu_src   & rst_n;
    assign reg_write = w_reg_write & rst_n;
    assign mem_read  = w_mem_read  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign mem2reg   = w_mem2reg   & rst_n;
    assign alu_op    = w_alu_op    & {2{rst_n}};
    assign int_ack   = w_int_ack   & rst_n;
    assign illegal   = r_illegal;
    assign bus_err   = r_bus_err;
    assign halted    = (r_state == S_HALT);
    assign retired   = r_retired;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-cycle expected control words are
// queued with their stimulus and compared as the sequencer steps.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'h00;
    logic        zero = 1'b0, int_req = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic        imem_req, dmem_req, ir_we, pc_we, reg_dst, alu_src, reg_write;
    logic        mem_read, mem_write, mem2reg, int_ack, illegal, bus_err, halted;
    logic [1:0]  pc_sel, alu_op;
    logic [15:0] retired;

    mc_sequencer #(.WAIT_MAX(8), .MAX_INSTR(3), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .int_req(int_req),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .dmem_req(dmem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .reg_dst(reg_dst), .alu_src(alu_src), .reg_write(reg_write),
        .mem_read(mem_read), .mem_write(mem_write), .mem2reg(mem2reg),
        .alu_op(alu_op), .int_ack(int_ack), .illegal(illegal), .bus_err(bus_err),
        .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    // Control-word bit masks: {imem_req,dmem_req,ir_we,pc_we,pc_sel,reg_dst,alu_src,
    // reg_write,mem_read,mem_write,mem2reg,alu_op,int_ack,illegal,bus_err,halted}
    localparam logic [17:0] IMEM = 18'h20000, DMEM = 18'h10000, IRWE = 18'h08000;
    localparam logic [17:0] PCWE = 18'h04000, SEL_BR = 18'h01000, SEL_J = 18'h02000;
    localparam logic [17:0] SEL_EP = 18'h03000, RDST = 18'h00800, ASRC = 18'h00400;
    localparam logic [17:0] RW = 18'h00200, MR = 18'h00100, MW = 18'h00080;
    localparam logic [17:0] M2R = 18'h00040, AOP_SUB = 18'h00010, AOP_FN = 18'h00020;
    localparam logic [17:0] ACK = 18'h00008, ILL = 18'h00004, BERR = 18'h00002;
    localparam logic [17:0] HLT = 18'h00001, NONE = 18'h00000;
    localparam logic [5:0]  OP_R = 6'h00, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0]  OP_BEQ = 6'h04, OP_J = 6'h02, OP_BAD = 6'h3F;

    typedef struct {
        logic [5:0]  op;
        logic        z, irq, ir, dr;
        logic [17:0] cw;
        logic [15:0] ret;
    } cyc_t;

    cyc_t        sbq[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] m_ret = 16'd0;
    logic        m_ill = 1'b0;
    logic        m_berr = 1'b0;

    function automatic logic [17:0] ctl();
        return {imem_req, dmem_req, ir_we, pc_we, pc_sel, reg_dst, alu_src, reg_write,
                mem_read, mem_write, mem2reg, alu_op, int_ack, illegal, bus_err, halted};
    endfunction

    // Queue one cycle of stimulus with the expected control word and retire count.
    task automatic push(input logic [5:0] op, input logic z, input logic irq,
                        input logic ir, input logic dr, input logic [17:0] cw);
        cyc_t e;
        e.op = op; e.z = z; e.irq = irq; e.ir = ir; e.dr = dr;
        e.cw = cw | (m_ill ? ILL : NONE) | (m_berr ? BERR : NONE);
        e.ret = m_ret;
        sbq.push_back(e);
    endtask

    task automatic apply(input cyc_t e);
        opcode = e.op; zero = e.z; int_req = e.irq; imem_ready = e.ir; dmem_ready = e.dr;
    endtask

    task automatic rst_assert();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        opcode = 6'h00; zero = 1'b0; int_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        m_ret = 16'd0; m_ill = 1'b0; m_berr = 1'b0;
        sbq.delete();
    endtask

    task automatic rst_release();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cyc_t e;
        rst_assert();
        #1;
        n_cmp++;
        if (ctl() !== NONE) begin n_err++; $display("FAIL reset_ctl got %h want %h", ctl(), NONE); end
        n_cmp++;
        if (retired !== 16'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", retired); end
        rst_release();
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_R, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, RDST | AOP_FN);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL reset_seq ctl got %h want %h", ctl(), e.cw); end
        end
        // Next edge enters WB; reset must kill its reg_write at once.
        rst_assert();
        #1;
        n_cmp++;
        if (ctl() !== NONE) begin n_err++; $display("FAIL reset_midinstr ctl got %h want %h", ctl(), NONE); end
        rst_release();
    endtask

    task automatic test_rtype();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_R, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, RDST | AOP_FN);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, RW | RDST | AOP_FN); m_ret++;
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL rtype ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL rtype retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_lw_wait();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_LW, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, ASRC);
        for (int i = 0; i < 3; i++) push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, DMEM | MR | ASRC);
        push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b1, DMEM | MR | ASRC);
        push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, RW | M2R); m_ret++;
        push(OP_LW, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL lw_wait ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL lw_wait retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_beq();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_BEQ, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_BEQ, 1'b1, 1'b0, 1'b0, 1'b0, SEL_BR | PCWE | AOP_SUB); m_ret++;
        push(OP_BEQ, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, SEL_BR | AOP_SUB); m_ret++;
        push(OP_BEQ, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL beq ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL beq retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_sw_irq();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_SW, 1'b0, 1'b1, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_SW, 1'b0, 1'b1, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_SW, 1'b0, 1'b1, 1'b0, 1'b0, NONE);
        push(OP_SW, 1'b0, 1'b1, 1'b0, 1'b0, ASRC);
        push(OP_SW, 1'b0, 1'b1, 1'b0, 1'b0, DMEM | MW | ASRC);
        push(OP_SW, 1'b0, 1'b1, 1'b0, 1'b1, DMEM | MW | ASRC | ACK); m_ret++;
        push(OP_SW, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_SW, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL sw_irq ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL sw_irq retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_illegal_timeout();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_BAD, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_BAD, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_BAD, 1'b0, 1'b1, 1'b0, 1'b0, NONE); m_ill = 1'b1;
        for (int i = 0; i < 8; i++) push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        m_berr = 1'b1;
        for (int i = 0; i < 3; i++) push(OP_R, 1'b0, 1'b1, 1'b1, 1'b1, HLT);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL illegal_timeout ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL illegal_timeout retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_wait_boundary();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        for (int i = 0; i < 7; i++) push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        push(OP_J, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, SEL_J | PCWE); m_ret++;
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, IMEM);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL wait_boundary ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL wait_boundary retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_back_to_back();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_SW, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        push(OP_SW, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_SW, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_SW, 1'b0, 1'b0, 1'b0, 1'b0, ASRC);
        push(OP_SW, 1'b0, 1'b0, 1'b0, 1'b1, DMEM | MW | ASRC); m_ret++;
        push(OP_R, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, RDST | AOP_FN);
        push(OP_R, 1'b0, 1'b0, 1'b0, 1'b0, RW | RDST | AOP_FN); m_ret++;
        push(OP_J, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, SEL_J | PCWE); m_ret++;
        push(OP_J, 1'b0, 1'b0, 1'b1, 1'b1, HLT);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL back_to_back ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL back_to_back retired got %0d want %0d", retired, e.ret); end
        end
    endtask

    task automatic test_halt();
        cyc_t e;
        rst_assert(); rst_release();
        push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, PCWE | SEL_EP);
        for (int k = 0; k < 3; k++) begin
            push(OP_J, 1'b0, 1'b0, 1'b1, 1'b0, IMEM | IRWE | PCWE);
            push(OP_J, 1'b0, 1'b0, 1'b0, 1'b0, NONE);
            // Interrupt pending on the final retire must lose to the halt.
            push(OP_J, 1'b0, (k == 2), 1'b0, 1'b0, SEL_J | PCWE); m_ret++;
        end
        for (int i = 0; i < 3; i++) push(OP_J, 1'b0, 1'b1, 1'b1, 1'b1, HLT);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            @(negedge clk); apply(e); #1;
            n_cmp++;
            if (ctl() !== e.cw) begin n_err++; $display("FAIL halt ctl got %h want %h", ctl(), e.cw); end
            n_cmp++;
            if (retired !== e.ret) begin n_err++; $display("FAIL halt retired got %0d want %0d", retired, e.ret); end
        end
        rst_assert();
        #1;
        n_cmp++;
        if (ctl() !== NONE) begin n_err++; $display("FAIL halt_reset ctl got %h want %h", ctl(), NONE); end
        n_cmp++;
        if (retired !== 16'd0) begin n_err++; $display("FAIL halt_reset retired got %0d want 0", retired); end
        rst_release();
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_sw_irq();
        test_illegal_timeout();
        test_wait_boundary();
        test_back_to_back();
        test_halt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
